// File: rtl/lab9_irq_ctrl.sv
// Interrupt controller for lab9: level/edge latched, masked sources -> one registered CPU irq.
// Latency: irq_in rising to irq high is S+2 clk (S = sampling stages); register reads take 1 clk.
// Backpressure: none; Avalon-MM slave with zero wait states, every access completes in one cycle.
//
// Build option: define IRQ_SYNC_EN for a two-flop input synchronizer (S=2); otherwise S=1 and
// every irq_in source must be synchronous to clk.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   address          register word address (0 RAW, 1 PENDING, 2 ENABLE, 3 ACTIVE, 4 ID, 5 EDGE_MODE)
//   chipselect       slave select; write = chipselect & ~write_n
//   write_n          active-low write strobe
//   writedata        write data (bits at or above NUM_SRC ignored)
//   readdata         registered read data, loaded from address every cycle
//   irq_in           source request lines, active-high, bit 0 = timer
//   irq              registered interrupt request to the CPU
//   irq_id           registered index of the lowest-numbered active source (0 if none)
module lab9_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq,
    output logic [3:0]         irq_id
);

    localparam logic [2:0] ADDR_RAW     = 3'd0;
    localparam logic [2:0] ADDR_PENDING = 3'd1;
    localparam logic [2:0] ADDR_ENABLE  = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_ID      = 3'd4;
    localparam logic [2:0] ADDR_EDGE    = 3'd5;

    logic [NUM_SRC-1:0] s;          // sampled requests
    logic [NUM_SRC-1:0] s_d;        // previous sample, for rising-edge detect
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] edge_mode;

    logic [NUM_SRC-1:0] wd;
    logic               wr;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] edge_on;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [3:0]         pe_id;
    logic               any_active;
    logic [15:0]        rd_mux;
    logic               unused_wd;

    assign wd        = writedata[NUM_SRC-1:0];
    assign unused_wd = ^writedata[15:NUM_SRC];
    assign wr        = chipselect & ~write_n;

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s      <= '0;
            s_d    <= '0;
        end else begin
            sync_q <= irq_in;
            s      <= sync_q;
            s_d    <= s;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s   <= '0;
            s_d <= '0;
        end else begin
            s   <= irq_in;
            s_d <= s;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pending update and priority encode
    // ------------------------------------------------------------------
    assign active     = pending & enable;
    assign any_active = |active;
    assign rise       = s & ~s_d;
    assign w1c        = (wr && address == ADDR_PENDING) ? wd : '0;
    // Sources switching from level to edge this cycle start with a clean pending bit.
    assign edge_on    = (wr && address == ADDR_EDGE) ? (wd & ~edge_mode) : '0;

    always_comb begin
        // Edge sources: a new edge beats a simultaneous W1C so no event is lost.
        // Level sources simply track the sampled line; W1C has no lasting effect.
        pending_nxt = (edge_mode & (rise | (pending & ~w1c))) | (~edge_mode & s);
        pending_nxt = pending_nxt & ~edge_on;
    end

    // Lowest index wins: scan from the top so the last hit is the lowest index.
    always_comb begin
        pe_id = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                pe_id = 4'(i);
            end
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            ADDR_RAW:     rd_mux = 16'(s);
            ADDR_PENDING: rd_mux = 16'(pending);
            ADDR_ENABLE:  rd_mux = 16'(enable);
            ADDR_ACTIVE:  rd_mux = 16'(active);
            ADDR_ID:      rd_mux = {any_active, 11'b0, pe_id};
            ADDR_EDGE:    rd_mux = 16'(edge_mode);
            default:      rd_mux = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            enable    <= '0;
            edge_mode <= '0;
            irq       <= 1'b0;
            irq_id    <= 4'd0;
            readdata  <= 16'h0000;
        end else begin
            pending  <= pending_nxt;
            irq      <= any_active;
            irq_id   <= pe_id;
            readdata <= rd_mux;
            if (wr && address == ADDR_ENABLE) begin
                enable <= wd;
            end
            if (wr && address == ADDR_EDGE) begin
                edge_mode <= wd;
            end
        end
    end

endmodule

// File: tb/tb_lab9_irq_ctrl.sv
// Self-checking bench for lab9_irq_ctrl: directed scenarios with literal expectations,
// then randomized bus traffic and request lines compared every cycle to a behavioural model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_lab9_irq_ctrl;

    localparam int N = 8;
`ifdef IRQ_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [N-1:0] irq_in;
    logic        irq;
    logic [3:0]  irq_id;

    lab9_irq_ctrl #(.NUM_SRC(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq),
        .irq_id     (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    logic [N-1:0] m_pend, m_en, m_edge;
    logic         m_irq;
    logic [3:0]   m_id;
    logic [15:0]  m_rd;
    logic [N-1:0] hist [0:2];   // hist[k] = irq_in captured k+1 clock edges ago

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_edge = '0;
        m_irq = 1'b0; m_id = 4'd0; m_rd = 16'h0;
        for (int k = 0; k < 3; k++) hist[k] = '0;
    endtask

    // One clock edge of the controller, computed from the register-map rules.
    task automatic model_step();
        logic [N-1:0] sv, sdv, act, wd, pn;
        logic         wrq;
        sv  = hist[S-1];
        sdv = hist[S];
        act = m_pend & m_en;
        wrq = chipselect && !write_n;
        wd  = writedata[N-1:0];
        case (address)
            3'd0:    m_rd = {8'h00, sv};
            3'd1:    m_rd = {8'h00, m_pend};
            3'd2:    m_rd = {8'h00, m_en};
            3'd3:    m_rd = {8'h00, act};
            3'd4:    m_rd = {act != 0, 11'b0, lowest(act)};
            3'd5:    m_rd = {8'h00, m_edge};
            default: m_rd = 16'h0;
        endcase
        m_irq = (act != 0);
        m_id  = lowest(act);
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                if (sv[i] && !sdv[i])                  pn[i] = 1'b1;
                else if (wrq && address == 3'd1 && wd[i]) pn[i] = 1'b0;
                else                                   pn[i] = m_pend[i];
            end else begin
                pn[i] = sv[i];
            end
            if (wrq && address == 3'd5 && wd[i] && !m_edge[i]) pn[i] = 1'b0;
        end
        m_pend = pn;
        if (wrq && address == 3'd2) m_en = wd;
        if (wrq && address == 3'd5) m_edge = wd;
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq_in;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_irq", {15'b0, irq}, {15'b0, m_irq});
            check("model_irq_id", {12'b0, irq_id}, {12'b0, m_id});
            check("model_readdata", readdata, m_rd);
        end
    end

    task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [15:0] d, input logic [N-1:0] iv);
        address = a; chipselect = cs; write_n = wn; writedata = d; irq_in = iv;
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [N-1:0] iv);
        cyc(a, 1'b1, 1'b0, d, iv);
    endtask

    task automatic rd(input logic [2:0] a, input logic [N-1:0] iv);
        cyc(a, 1'b1, 1'b1, 16'h0, iv);
    endtask

    initial begin
        int lat;
        logic [N-1:0] rv;
        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 16'h0; irq_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        reset = 1'b0;

        // 1. reset state
        check("rst_irq", {15'b0, irq}, 16'h0);
        check("rst_irq_id", {12'b0, irq_id}, 16'h0);
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), '0);
            check("rst_read", readdata, 16'h0);
        end

        // 2. level mode latency and W1C with source held
        wr(3'd2, 16'h0001, '0);
        lat = 0;
        do begin rd(3'd0, 8'h01); lat++; end while (irq !== 1'b1 && lat < 20);
        check("lvl_rise_latency", 16'(lat), 16'(S + 2));
        check("lvl_irq_id", {12'b0, irq_id}, 16'h0);
        wr(3'd1, 16'h0001, 8'h01);
        rd(3'd1, 8'h01);
        check("lvl_w1c_pending", readdata, 16'h0001);
        lat = 0;
        do begin rd(3'd0, 8'h00); lat++; end while (irq !== 1'b0 && lat < 20);
        check("lvl_fall_latency", 16'(lat), 16'(S + 2));

        // 3. edge mode pulse, hold, clear
        wr(3'd5, 16'h0004, '0);
        wr(3'd2, 16'h0004, '0);
        rd(3'd0, 8'h04);
        repeat (S + 2) rd(3'd0, '0);
        check("edge_irq", {15'b0, irq}, 16'h0001);
        check("edge_irq_id", {12'b0, irq_id}, 16'h0002);
        rd(3'd1, '0);
        check("edge_pending_held", readdata, 16'h0004);
        wr(3'd1, 16'h0004, '0);
        rd(3'd0, '0);
        check("edge_irq_cleared", {15'b0, irq}, 16'h0);
        rd(3'd1, '0);
        check("edge_pending_cleared", readdata, 16'h0000);

        // 4. priority between sources 3 and 5
        wr(3'd5, 16'h0028, '0);
        wr(3'd2, 16'h00FF, '0);
        rd(3'd0, 8'h28);
        repeat (S + 2) rd(3'd0, '0);
        rd(3'd4, '0);
        check("prio_id_read", readdata, 16'h8003);
        check("prio_irq_id", {12'b0, irq_id}, 16'h0003);
        wr(3'd1, 16'h0008, '0);
        rd(3'd0, '0);
        rd(3'd4, '0);
        check("prio_id_after_clear", readdata, 16'h8005);
        check("prio_irq_id_after_clear", {12'b0, irq_id}, 16'h0005);
        wr(3'd1, 16'h0020, '0);

        // 5. edge and W1C on the same cycle: set wins
        wr(3'd5, 16'h0002, '0);
        rd(3'd0, 8'h02);
        repeat (S - 1) rd(3'd0, 8'h02);
        wr(3'd1, 16'h0002, 8'h02);
        rd(3'd1, 8'h02);
        check("edge_vs_w1c", readdata, 16'h0002);
        wr(3'd1, 16'h0002, '0);

        // 6. masking, then asynchronous reset
        wr(3'd2, 16'h0000, '0);
        wr(3'd5, 16'h0040, '0);
        rd(3'd0, 8'h40);
        repeat (S + 2) rd(3'd0, '0);
        rd(3'd3, '0);
        check("mask_active", readdata, 16'h0000);
        check("mask_irq", {15'b0, irq}, 16'h0);
        rd(3'd1, '0);
        check("mask_pending", readdata, 16'h0040);
        wr(3'd2, 16'h0040, '0);
        rd(3'd0, '0);
        rd(3'd0, '0);
        check("unmask_irq", {15'b0, irq}, 16'h0001);
        check("unmask_irq_id", {12'b0, irq_id}, 16'h0006);
        #2 reset = 1'b1;
        #1;
        check("arst_irq", {15'b0, irq}, 16'h0);
        check("arst_irq_id", {12'b0, irq_id}, 16'h0);
        check("arst_readdata", readdata, 16'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int a = 1; a < 6; a++) begin
            rd(3'(a), '0);
            check("post_arst_read", readdata, 16'h0);
        end

        // Randomized traffic, compared every cycle against the model
        rv = '0;
        for (int n = 0; n < 4000; n++) begin
            rv = rv ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) != 0), 16'($urandom), rv);
            if ($urandom_range(0, 999) == 0) begin
                #3 reset = 1'b1;
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lab9_irq_ctrl.md
Name: lab9_irq_ctrl

Overview:
Avalon-MM interrupt controller that sits directly downstream of the interval timer and the other lab9 peripherals.
- Collects up to NUM_SRC interrupt request lines; bit 0 is the timer irq by system convention.
- Latches requests per source as level or edge, masks them, and drives a single registered irq to the CPU.
- Reports the highest-priority active source so the ISR dispatches without scanning.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq_in  in  NUM_SRC  source request lines, active-high
irq  out  1  interrupt request to CPU, registered
irq_id  out  4  index of the highest-priority active source (0 if none), registered

Behaviour:
- Reset is asynchronous, active-high, on clk/reset only. All registers clear on reset: readdata=0, irq=0, irq_id=0, pending=0, enable=0, edge_mode=0, and the sampling stages = 0.
- Reset mid-operation discards all pending state immediately. No pulse on irq after reset deassertion unless a source is enabled again.
- Input sampling: irq_in passes through S sampling stages to produce s[]. S=2 with IRQ_SYNC_EN, S=1 without. A further register s_d holds the previous s.
- Per-source pending update, each clk, for source i:
  - edge_mode[i]=0 (level): pending[i] <= s[i]. W1C has no lasting effect while the source remains asserted.
  - edge_mode[i]=1 (edge): pending[i] set when s[i] & ~s_d[i]; cleared by a W1C write of 1 to bit i.
  - Edge and W1C on the same cycle: set wins, so no event is lost.
- active = pending & enable.
- irq <= |active, registered.
- irq_id <= lowest index i with active[i]=1 (lowest index = highest priority); 0 when active=0.
- Latency, irq_in rising to irq high:
  - Edge mode: S+2 cycles (4 with IRQ_SYNC_EN, 3 without).
  - Level mode: the same.
- Register map (word address; write = chipselect & ~write_n; unused bits read 0):
  - 0 RAW (RO): s[NUM_SRC-1:0].
  - 1 PENDING (R/W1C): pending. Writing 1 clears edge-mode bits; level-mode bits are ignored.
  - 2 ENABLE (RW): enable mask.
  - 3 ACTIVE (RO): pending & enable.
  - 4 ID (RO): bit15 = |active, bits3:0 = combinational priority encode of active (the same value irq_id takes next cycle).
  - 5 EDGE_MODE (RW): per-source mode.
  - 6,7: read 0, writes ignored.
- readdata <= mux(address) every cycle, regardless of chipselect: one-cycle read latency, no wait states.
- Mode change:
  - Writing EDGE_MODE bit i from 0 to 1 clears pending[i] in the same cycle.
  - 1 to 0 reloads pending[i] from s[i] on the next update.
- Enable write takes effect on active immediately and on irq one cycle later. Disabling a source does not clear its pending bit.
- Bits at or above NUM_SRC in writedata are ignored.

Optional Feature:
IRQ_SYNC_EN
- Defined: irq_in passes through a two-flop synchronizer (S=2) and may be asynchronous to clk.
- Undefined: a single register stage (S=1); all sources must be synchronous to clk; latency is one cycle shorter.
- Register map and all other behaviour are identical in both builds.

Test Plan:
1. Reset then read addr 0..5 -> all readdata=0, irq=0, irq_id=0.
2. Level mode: enable=0x0001, drive irq_in[0]=1 at cycle k -> irq=1 at k+4 (IRQ_SYNC_EN) / k+3 (without), irq_id=0. Deassert -> irq returns to 0 after the same latency; PENDING W1C while asserted leaves PENDING=0x0001.
3. Edge mode: EDGE_MODE=0x0004, enable=0x0004, one-cycle pulse on irq_in[2] -> PENDING=0x0004 held, irq=1, irq_id=2. Write PENDING=0x0004 -> PENDING=0, irq=0 the cycle after.
4. Priority: enable=0x00FF, pending sources 5 and 3 -> ID read=0x8003, irq_id=3. Clear 3 -> ID=0x8005.
5. Simultaneous edge on source 1 and W1C of bit 1 in the same cycle -> PENDING bit 1 remains 1.
6. Masking and reset: source 6 pending, enable=0 -> ACTIVE=0, irq=0, PENDING=0x0040. Assert reset asynchronously mid-test -> irq and all registers 0 without a clock edge.
